camera_fe_scheduler: RTL



---
 rtl/camera_fe_scheduler.sv | 97 +++++++++
 1 files changed

// File: rtl/camera_fe_scheduler.sv
// Single-frame scheduler between a camera source and a feature extractor.
// Launches one frame at a time, waits for the result (or a timeout) and holds it for the consumer.
module camera_fe_scheduler #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ID_W           = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3071:0]     in_image,
  output logic              fe_start,
  output logic [3071:0]     fe_image,
  input  logic              fe_valid,
  input  logic [255:0]      fe_feature,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [255:0]      out_feature,
  output logic [ID_W-1:0]   out_frame_id,
  output logic              out_timeout,
  output logic              busy,
  output logic [7:0]        timeout_cnt
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

  state_t            state;
  logic [ID_W-1:0]   frame_id;
  logic [TMR_W-1:0]  timer;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fe_start     <= 1'b0;
      fe_image     <= '0;
      out_valid    <= 1'b0;
      out_feature  <= '0;
      out_frame_id <= '0;
      out_timeout  <= 1'b0;
      frame_id     <= '0;
      timer        <= '0;
      timeout_cnt  <= '0;
    end else begin
      fe_start <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            fe_image     <= in_image;
            out_frame_id <= frame_id;
            frame_id     <= frame_id + ID_W'(1);
            fe_start     <= 1'b1;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A result arriving on the expiry cycle still counts as a real result.
          if (fe_valid) begin
            out_feature <= fe_feature;
            out_timeout <= 1'b0;
            out_valid   <= 1'b1;
            state       <= HOLD;
          end else if (timer == TMR_LAST) begin
            out_feature <= '0;
            out_timeout <= 1'b1;
            out_valid   <= 1'b1;
            timeout_cnt <= sat_inc8(timeout_cnt);
            state       <= HOLD;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
